// File: rtl/pe_writeback_buffer.sv
// Tags PE array results with the destination register captured at issue and drains them
// in order through a small FIFO with credit-based issue backpressure. Option: WB_ZERO_FLAG_EN.
module pe_writeback_buffer #(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           flush,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  output logic                           issue_ready,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] pe_out,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [ADDR_WIDTH-1:0]          wb_rd,
  output logic [PE_COUNT*DATA_WIDTH-1:0] wb_data,
  output logic [$clog2(DEPTH):0]         count,
`ifdef WB_ZERO_FLAG_EN
  output logic [PE_COUNT-1:0]            wb_zero,
`endif
  output logic                           overflow_err
);

  localparam int VW = PE_COUNT * DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic                  tag_valid;
  logic [ADDR_WIDTH-1:0] tag_rd;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic [CW:0]           occupancy;

  logic [ADDR_WIDTH-1:0] mem_rd   [DEPTH];
  logic [VW-1:0]         mem_data [DEPTH];

  // Credit counts the in-flight tag as already occupying a slot, so the push that
  // follows an accepted issue always finds room; no path from wb_ready.
  always_comb begin
    occupancy   = {1'b0, count} + (CW+1)'(tag_valid);
    issue_ready = occupancy < (CW+1)'(DEPTH);
    wb_valid    = (count != '0);
    pop         = wb_valid && wb_ready && !flush;
    push        = tag_valid && !flush && ((count != CW'(DEPTH)) || pop);
    wb_rd       = wb_valid ? mem_rd[rd_ptr]   : '0;
    wb_data     = wb_valid ? mem_data[rd_ptr] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_valid    <= 1'b0;
      tag_rd       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      tag_rd <= issue_rd;
      if (issue_valid && !issue_ready) overflow_err <= 1'b1;
      if (flush) begin
        tag_valid <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
      end else begin
        tag_valid <= issue_valid && issue_ready;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the entry storage has no reset; validity is carried by count, and the
  // outputs are gated by wb_valid so stale contents never reach the register file.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= tag_rd;
      mem_data[wr_ptr] <= pe_out;
    end
  end

`ifdef WB_ZERO_FLAG_EN
  logic [PE_COUNT-1:0] mem_zero [DEPTH];
  logic [PE_COUNT-1:0] pe_zero;

  always_comb begin
    pe_zero = '0;
    for (int i = 0; i < PE_COUNT; i++)
      pe_zero[i] = (pe_out[i*DATA_WIDTH +: DATA_WIDTH] == '0);
    wb_zero = wb_valid ? mem_zero[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_zero[wr_ptr] <= pe_zero;
  end
`endif

endmodule

// File: tb/tb_pe_writeback_buffer.sv
// Scoreboard bench for pe_writeback_buffer: a driver models FIFO occupancy and credit
// and queues expected results; a negedge monitor checks every accepted head.
module tb_pe_writeback_buffer;

  localparam int PE_COUNT   = 4;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int ADDR_WIDTH = 5;
  localparam int VW         = PE_COUNT * DATA_WIDTH;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   flush;
  logic                   issue_valid;
  logic [ADDR_WIDTH-1:0]  issue_rd;
  logic                   issue_ready;
  logic [VW-1:0]          pe_out;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [ADDR_WIDTH-1:0]  wb_rd;
  logic [VW-1:0]          wb_data;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow_err;
`ifdef WB_ZERO_FLAG_EN
  logic [PE_COUNT-1:0]    wb_zero;
`endif

  pe_writeback_buffer #(
    .PE_COUNT(PE_COUNT), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .pe_out(pe_out), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .count(count),
`ifdef WB_ZERO_FLAG_EN
    .wb_zero(wb_zero),
`endif
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_WIDTH-1:0] rd;
    logic [VW-1:0]         data;
    logic [PE_COUNT-1:0]   zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: number of results held, whether one is in flight, sticky error.
  int                    m_count = 0;
  bit                    m_tag   = 1'b0;
  logic [ADDR_WIDTH-1:0] m_tag_rd = '0;
  bit                    m_ovf   = 1'b0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PE_COUNT-1:0] zero_flags(input logic [VW-1:0] v);
    logic [PE_COUNT-1:0] z;
    for (int i = 0; i < PE_COUNT; i++) z[i] = (v[i*DATA_WIDTH +: DATA_WIDTH] == 0);
    return z;
  endfunction

  function automatic logic [VW-1:0] rand_pe();
    logic [VW-1:0] v;
    for (int i = 0; i < PE_COUNT; i++)
      v[i*DATA_WIDTH +: DATA_WIDTH] = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom());
    return v;
  endfunction

  // Called at posedge+1: drive one cycle, check registered outputs, advance the model.
  task automatic step(input logic iv, input logic [ADDR_WIDTH-1:0] rd, input logic wbr,
                      input logic fl, input logic [VW-1:0] pe);
    bit   exp_ready;
    bit   do_pop;
    exp_t e;
    issue_valid = iv;
    issue_rd    = rd;
    wb_ready    = wbr;
    flush       = fl;
    pe_out      = pe;
    exp_ready = (m_count + int'(m_tag)) < DEPTH;
    check("issue_ready",  VW'(issue_ready),  VW'(exp_ready));
    check("count",        VW'(count),        VW'(m_count));
    check("wb_valid",     VW'(wb_valid),     VW'(m_count != 0));
    check("overflow_err", VW'(overflow_err), VW'(m_ovf));
    if (iv && !exp_ready) m_ovf = 1'b1;
    if (fl) begin
      m_count = 0;
      m_tag   = 1'b0;
      exp_q.delete();
    end else begin
      do_pop = (m_count > 0) && wbr;
      if (m_tag) begin
        e.rd   = m_tag_rd;
        e.data = pe;
        e.zero = zero_flags(pe);
        exp_q.push_back(e);
        m_count++;
      end
      if (do_pop) m_count--;
      m_tag    = iv && exp_ready;
      m_tag_rd = rd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid();
    #2;
    rstn = 1'b0;
    #1;
    check("rst_count",       VW'(count),        '0);
    check("rst_wb_valid",    VW'(wb_valid),     '0);
    check("rst_wb_rd",       VW'(wb_rd),        '0);
    check("rst_wb_data",     wb_data,           '0);
    check("rst_issue_ready", VW'(issue_ready),  VW'(1));
    check("rst_overflow",    VW'(overflow_err), '0);
`ifdef WB_ZERO_FLAG_EN
    check("rst_wb_zero",     VW'(wb_zero),      '0);
`endif
    issue_valid = 1'b0;
    flush       = 1'b0;
    wb_ready    = 1'b0;
    m_count = 0;
    m_tag   = 1'b0;
    m_ovf   = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: a handshake seen mid-cycle completes on the next edge.
  always @(negedge clk) begin
    if (rstn && !flush && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", VW'(wb_valid), '0);
      end else begin
        check("wb_rd",   VW'(wb_rd), VW'(exp_q[0].rd));
        check("wb_data", wb_data,    exp_q[0].data);
`ifdef WB_ZERO_FLAG_EN
        check("wb_zero", VW'(wb_zero), VW'(exp_q[0].zero));
`endif
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int acc;
    bit iv;
    rstn = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    wb_ready = 1'b0; pe_out = '0;
    #3;
    check("init_count",       VW'(count),       '0);
    check("init_issue_ready", VW'(issue_ready), VW'(1));
    check("init_wb_valid",    VW'(wb_valid),    '0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single op: rd=3, result {4,3,2,1}, visible two edges after issue.
    step(1, 5'd3, 1, 0, rand_pe());
    step(0, 5'd0, 1, 0, {32'd4, 32'd3, 32'd2, 32'd1});
    check("single_latency_valid", VW'(wb_valid), VW'(1));
    step(0, 5'd0, 1, 0, rand_pe());
    step(0, 5'd0, 1, 0, rand_pe());

    // Fill and stall, then drain in issue order.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      iv = issue_ready;
      step(iv, 5'(acc), 0, 0, rand_pe());
      if (iv) acc++;
    end
    check("fill_accepted", VW'(acc), VW'(DEPTH));
    for (int i = 0; i < 6; i++) step(0, 5'd0, 1, 0, rand_pe());

    // count=3 with a tag in flight, then simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1, 5'(10 + i), 0, 0, rand_pe());
    check("full_pp_count", VW'(count), VW'(3));
    for (int i = 0; i < 8; i++) step(issue_ready, 5'(20 + i), 1, 0, rand_pe());
    for (int i = 0; i < 6; i++) step(0, 5'd0, 1, 0, rand_pe());

    // Credit violation: issue while full is dropped and the error sticks.
    for (int i = 0; i < 6; i++) step(issue_ready, 5'(i), 0, 0, rand_pe());
    step(1, 5'd31, 0, 0, rand_pe());
    step(0, 5'd0, 0, 0, rand_pe());
    for (int i = 0; i < 6; i++) step(0, 5'd0, 1, 0, rand_pe());

    // Asynchronous reset mid-cycle with count=2 and a tag in flight.
    for (int i = 0; i < 3; i++) step(1, 5'(i), 0, 0, rand_pe());
    check("pre_reset_count", VW'(count), VW'(2));
    reset_mid();

    // Flush with count=3.
    for (int i = 0; i < 4; i++) step(1, 5'(i), 0, 0, rand_pe());
    step(0, 5'd0, 1, 1, rand_pe());
    check("flush_count",    VW'(count),    '0);
    check("flush_wb_valid", VW'(wb_valid), '0);
    step(0, 5'd0, 1, 0, rand_pe());

    // Zero-flag pattern {0,7,0,5}.
    step(1, 5'd9, 0, 0, rand_pe());
    step(0, 5'd0, 0, 0, {32'd0, 32'd7, 32'd0, 32'd5});
`ifdef WB_ZERO_FLAG_EN
    check("wb_zero_pattern", VW'(wb_zero), VW'(4'b1010));
`endif
    step(0, 5'd0, 1, 0, rand_pe());
    step(0, 5'd0, 1, 0, rand_pe());

    // Randomised traffic with occasional flushes and credit violations.
    for (int i = 0; i < 600; i++) begin
      iv = ($urandom_range(19) == 0) ? 1'b1 : (issue_ready && ($urandom_range(3) != 0));
      step(iv, 5'($urandom()), 1'($urandom_range(2) != 0),
           ($urandom_range(49) == 0), rand_pe());
    end

    for (int i = 0; i < 20 && (m_count > 0 || m_tag); i++) step(0, 5'd0, 1, 0, rand_pe());
    check("final_queue_empty", VW'(exp_q.size()), '0);
    check("final_count",       VW'(count),        '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_writeback_buffer.md
Name: pe_writeback_buffer

Overview:
- Sits directly downstream of the PE array and consumes its registered per-lane results (pe_out).
- The PE array carries no valid or tag, so this block does two jobs:
  - Tags each result with the destination vector register captured at issue time.
  - Buffers tagged results in a small FIFO and drains them to the vector register-file write port over a valid/ready handshake.
- Issues credit-based backpressure (issue_ready) to the issue stage so results are never lost.

Parameters:
- PE_COUNT, 4, number of lanes; must match the PE array.
- DATA_WIDTH, 32, bits per lane.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_WIDTH, 5, destination register address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of the FIFO and the in-flight tag.
- issue_valid  in  1  an op enters the PE array this cycle.
- issue_rd  in  ADDR_WIDTH  destination register of that op.
- issue_ready  out  1  credit available; the issue stage may assert issue_valid.
- pe_out  in  PE_COUNT*DATA_WIDTH  PE array result, valid one cycle after issue.
- wb_valid  out  1  FIFO head is valid.
- wb_ready  in  1  register file accepts the head.
- wb_rd  out  ADDR_WIDTH  head destination register.
- wb_data  out  PE_COUNT*DATA_WIDTH  head result vector.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_err  out  1  sticky; set on an issue made without credit.

Behaviour:
- Reset (rstn low, asynchronous): all registers clear immediately.
  - count=0, tag_valid=0, wb_valid=0, wb_rd=0, wb_data=0, overflow_err=0.
  - issue_ready=1.
  - A reset in mid-operation discards the in-flight tag and all FIFO contents.
- Tag stage:
  - On each clk edge, tag_valid<=issue_valid and tag_rd<=issue_rd.
  - This aligns with the PE array's one-cycle output register: an issue at edge N produces pe_out after edge N+1.
- Push: when tag_valid=1, {tag_rd, pe_out} is written at the tail on that edge.
  - pe_out is sampled in the same cycle tag_valid is high.
  - pe_out is ignored when tag_valid=0.
- Pop: when wb_valid && wb_ready, the head advances.
  - wb_valid = (count != 0).
  - wb_rd and wb_data are driven combinationally from the head entry.
  - wb_data is held stable while wb_valid=1 and wb_ready=0.
- Simultaneous push and pop: count is unchanged and both pointers advance; this is legal when count=DEPTH.
- Pointers:
  - Wrap modulo DEPTH.
  - count is updated by +1 (push only), -1 (pop only) or 0 (both or neither).
- Credit:
  - issue_ready = (count + tag_valid) < DEPTH.
  - It is computed from registers only, with no combinational path from wb_ready.
  - This guarantees the push arriving one cycle after issue always has space.
- Credit violation: issue_valid=1 with issue_ready=0.
  - The op is dropped: tag_valid<=0 for that op.
  - overflow_err<=1, cleared only by reset.
- Ordering: results drain strictly in issue order.
- flush=1:
  - Clears count, both pointers and tag_valid on the next edge.
  - Overrides push, pop and issue in that cycle.
  - overflow_err is unaffected.
- Latency: issue at edge N gives wb_valid=1 after edge N+2 when the FIFO was empty.

Optional Feature:
- Macro: WB_ZERO_FLAG_EN.
- Defined:
  - Adds output wb_zero [PE_COUNT]; bit i=1 when lane i of the pushed pe_out equals 0.
  - The flags are computed at push, stored per entry, and follow the head exactly like wb_data.
  - wb_zero resets to 0.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Single op: issue rd=3 at cycle 0, pe_out={4,3,2,1} at cycle 1, wb_ready=1 -> wb_valid=1 at cycle 2 with wb_rd=3, wb_data={4,3,2,1}; count returns to 0 after the pop.
- Fill and stall, DEPTH=4, wb_ready=0:
  - Issue every cycle while ready -> exactly 4 ops accepted; issue_ready falls to 0 once count+tag_valid=4; count=4.
  - Raise wb_ready -> entries drain in issue order rd=0,1,2,3.
- Full with simultaneous push and pop: count=3, tag_valid=1, wb_ready=1 -> count stays 3 and data order is preserved.
- Credit violation: force issue_valid=1 while issue_ready=0 -> no push, count unchanged, overflow_err=1 and it stays 1 after the FIFO drains.
- Reset and flush:
  - Assert rstn=0 mid-cycle with count=2 and tag_valid=1 -> outputs clear immediately, issue_ready=1.
  - flush with count=3 -> count=0 and wb_valid=0 on the next edge.
- With WB_ZERO_FLAG_EN: push pe_out={0,7,0,5} -> wb_zero=4'b1010 at the head.
